// File: rtl/sprite_renderer_if.sv
`default_nettype none
// ============================================================================
// Module  : sprite_renderer_if
// Purpose : Control/pixel bundle between the game controller and the sprite
//           renderer (frame request, per-slot object data, VGA pixel stream).
// Rev     : 1.0  initial release
// ============================================================================
interface sprite_renderer_if #(
  parameter int NUM_OBJ  = 4,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
);
  logic                         draw;
  logic [NUM_OBJ*X_W-1:0]       obj_x;
  logic [NUM_OBJ*Y_W-1:0]       obj_y;
  logic [NUM_OBJ*COLOUR_W-1:0]  obj_colour;
  logic [NUM_OBJ-1:0]           obj_valid;
  logic [X_W-1:0]               vga_x;
  logic [Y_W-1:0]               vga_y;
  logic [COLOUR_W-1:0]          vga_colour;
  logic                         vga_plot;
  logic                         finish_drawing;
  logic                         busy;

  modport master (
    output draw, obj_x, obj_y, obj_colour, obj_valid,
    input  vga_x, vga_y, vga_colour, vga_plot, finish_drawing, busy
  );

  modport slave (
    input  draw, obj_x, obj_y, obj_colour, obj_valid,
    output vga_x, vga_y, vga_colour, vga_plot, finish_drawing, busy
  );
endinterface
`default_nettype wire

// File: rtl/sprite_renderer.sv
`default_nettype none
// ============================================================================
// Module  : sprite_renderer
// Purpose : Per frame, erases every object's previous square then paints its
//           current square, one pixel per cycle, and pulses finish_drawing.
// Rev     : 1.0  initial release
// ============================================================================
module sprite_renderer #(
  parameter int NUM_OBJ   = 4,
  parameter int SIZE      = 4,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int COLOUR_W  = 3,
  parameter int X_MAX     = 159,
  parameter int Y_MAX     = 119,
  parameter int BG_COLOUR = 0
) (
  input  logic             clock,
  input  logic             reset,
  sprite_renderer_if.slave bus
);
  localparam int c_slot_w = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int c_d_w    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [c_slot_w-1:0] c_last_slot = c_slot_w'(NUM_OBJ - 1);
  localparam logic [c_d_w-1:0]    c_last_d    = c_d_w'(SIZE - 1);
  localparam logic [X_W:0]        c_x_max     = (X_W + 1)'(X_MAX);
  localparam logic [Y_W:0]        c_y_max     = (Y_W + 1)'(Y_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ERASE = 3'd2,
    S_PAINT = 3'd3,
    S_DONE  = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  state_t                      r_state;
  logic [c_slot_w-1:0]         r_slot;
  logic [c_d_w-1:0]            r_dx;
  logic [c_d_w-1:0]            r_dy;
  logic [NUM_OBJ*X_W-1:0]      r_new_x;
  logic [NUM_OBJ*Y_W-1:0]      r_new_y;
  logic [NUM_OBJ*COLOUR_W-1:0] r_new_colour;
  logic [NUM_OBJ-1:0]          r_new_valid;
  logic [NUM_OBJ*X_W-1:0]      r_old_x;
  logic [NUM_OBJ*Y_W-1:0]      r_old_y;
  logic [NUM_OBJ-1:0]          r_old_valid;

  logic            w_erase;
  logic            w_sweep;
  logic [X_W-1:0]  w_base_x;
  logic [Y_W-1:0]  w_base_y;
  logic [X_W:0]    w_sum_x;
  logic [Y_W:0]    w_sum_y;
  logic            w_slot_valid;
  logic            w_on_screen;
  logic            w_slot_end;

  assign w_erase = (r_state == S_ERASE);
  assign w_sweep = w_erase || (r_state == S_PAINT);

  // Erase walks the shadow copy of last frame; paint walks the latched frame.
  always_comb begin
    w_base_x     = w_erase ? r_old_x[r_slot*X_W +: X_W] : r_new_x[r_slot*X_W +: X_W];
    w_base_y     = w_erase ? r_old_y[r_slot*Y_W +: Y_W] : r_new_y[r_slot*Y_W +: Y_W];
    w_slot_valid = w_erase ? r_old_valid[r_slot] : r_new_valid[r_slot];
    w_sum_x      = {1'b0, w_base_x} + (X_W + 1)'(r_dx);
    w_sum_y      = {1'b0, w_base_y} + (Y_W + 1)'(r_dy);
    w_on_screen  = (w_sum_x <= c_x_max) && (w_sum_y <= c_y_max);
    w_slot_end   = !w_slot_valid || ((r_dx == c_last_d) && (r_dy == c_last_d));
  end

  assign bus.vga_x          = w_sweep ? w_sum_x[X_W-1:0] : '0;
  assign bus.vga_y          = w_sweep ? w_sum_y[Y_W-1:0] : '0;
  assign bus.vga_colour     = (r_state == S_PAINT) ? r_new_colour[r_slot*COLOUR_W +: COLOUR_W] :
                              (w_erase ? COLOUR_W'(BG_COLOUR) : '0);
  assign bus.vga_plot       = w_sweep && w_slot_valid && w_on_screen;
  assign bus.finish_drawing = (r_state == S_DONE);
  assign bus.busy           = (r_state != S_IDLE) && (r_state != S_HOLD);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_slot       <= '0;
      r_dx         <= '0;
      r_dy         <= '0;
      r_new_x      <= '0;
      r_new_y      <= '0;
      r_new_colour <= '0;
      r_new_valid  <= '0;
      r_old_x      <= '0;
      r_old_y      <= '0;
      r_old_valid  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.draw) r_state <= S_LOAD;
        S_LOAD: begin
          r_new_x      <= bus.obj_x;
          r_new_y      <= bus.obj_y;
          r_new_colour <= bus.obj_colour;
          r_new_valid  <= bus.obj_valid;
          r_slot       <= '0;
          r_dx         <= '0;
          r_dy         <= '0;
          r_state      <= S_ERASE;
        end
        S_ERASE, S_PAINT: begin
          if (w_slot_end) begin
            r_dx <= '0;
            r_dy <= '0;
            if (r_slot == c_last_slot) begin
              r_slot <= '0;
              if (w_erase) begin
                r_state <= S_PAINT;
              end else begin
                // What was just painted is what next frame must erase.
                r_old_x     <= r_new_x;
                r_old_y     <= r_new_y;
                r_old_valid <= r_new_valid;
                r_state     <= S_DONE;
              end
            end else begin
              r_slot <= r_slot + 1'b1;
            end
          end else if (r_dx == c_last_d) begin
            r_dx <= '0;
            r_dy <= r_dy + 1'b1;
          end else begin
            r_dx <= r_dx + 1'b1;
          end
        end
        S_DONE:  r_state <= S_HOLD;
        S_HOLD:  if (!bus.draw) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sprite_renderer.sv
`default_nettype none
// ============================================================================
// Module  : tb_sprite_renderer
// Purpose : Self-checking bench for sprite_renderer against a pixel-list model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sprite_renderer;
  localparam int NUM_OBJ = 2, SIZE = 2, X_W = 8, Y_W = 7, COLOUR_W = 3;
  localparam int X_MAX = 159, Y_MAX = 119, BG_COLOUR = 0;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  sprite_renderer_if #(.NUM_OBJ(NUM_OBJ), .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W)) bus ();

  sprite_renderer #(
    .NUM_OBJ(NUM_OBJ), .SIZE(SIZE), .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W),
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .BG_COLOUR(BG_COLOUR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic busy; logic plot; logic finish; logic chk;
    int x; int y; int c;
  } exp_t;
  typedef struct packed { logic [7:0] x; logic [6:0] y; logic [2:0] c; } pix_t;

  exp_t q[$];
  exp_t cur;
  pix_t plot_log[$];
  int   busy_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   mode = 0;
  bit   pending = 0;
  bit   started = 0;
  int   sh_x[NUM_OBJ];
  int   sh_y[NUM_OBJ];
  bit   sh_v[NUM_OBJ];

  function automatic exp_t mk(bit b, bit p, bit f, bit k, int x, int y, int c);
    exp_t e;
    e.busy = b; e.plot = p; e.finish = f; e.chk = k; e.x = x; e.y = y; e.c = c;
    return e;
  endfunction

  // A valid square is SIZE*SIZE pixels in raster order; an empty slot is one idle cycle.
  task automatic push_square(int bx, int by, bit v, int c);
    if (!v) begin
      q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    end else begin
      for (int dy = 0; dy < SIZE; dy++)
        for (int dx = 0; dx < SIZE; dx++)
          q.push_back(mk(1, (bx + dx <= X_MAX) && (by + dy <= Y_MAX), 0, 1,
                         (bx + dx) % 256, (by + dy) % 128, c));
    end
  endtask

  // Reference model: 0 idle, 1 frame in flight, 2 waiting for draw to drop.
  initial begin
    forever begin
      @(posedge clock);
      started = 1;
      if (!reset) begin
        q.delete();
        mode = 0;
        pending = 0;
        for (int i = 0; i < NUM_OBJ; i++) begin sh_x[i] = 0; sh_y[i] = 0; sh_v[i] = 0; end
      end else begin
        case (mode)
          0: if (bus.draw) begin
               q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
               pending = 1;
               mode = 1;
             end
          1: if (pending) begin
               pending = 0;
               for (int i = 0; i < NUM_OBJ; i++) push_square(sh_x[i], sh_y[i], sh_v[i], BG_COLOUR);
               for (int i = 0; i < NUM_OBJ; i++) begin
                 sh_x[i] = int'(bus.obj_x[i*X_W +: X_W]);
                 sh_y[i] = int'(bus.obj_y[i*Y_W +: Y_W]);
                 sh_v[i] = bus.obj_valid[i];
                 push_square(sh_x[i], sh_y[i], sh_v[i], int'(bus.obj_colour[i*COLOUR_W +: COLOUR_W]));
               end
               q.push_back(mk(1, 0, 1, 0, 0, 0, 0));
             end else if (q.size() == 0) begin
               mode = 2;
             end
          default: if (!bus.draw) mode = 0;
        endcase
      end
      cur = (q.size() > 0) ? q.pop_front() : mk(0, 0, 0, 1, 0, 0, 0);
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (started) begin
        n_checks++;
        if (bus.busy !== cur.busy || bus.vga_plot !== cur.plot || bus.finish_drawing !== cur.finish) begin
          n_errors++;
          $display("FAIL ctrl @%0t: busy/plot/finish got %b%b%b expected %b%b%b", $time,
                   bus.busy, bus.vga_plot, bus.finish_drawing, cur.busy, cur.plot, cur.finish);
        end
        if (cur.chk) begin
          n_checks++;
          if (bus.vga_x !== X_W'(cur.x) || bus.vga_y !== Y_W'(cur.y) || bus.vga_colour !== COLOUR_W'(cur.c)) begin
            n_errors++;
            $display("FAIL pixel @%0t: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)", $time,
                     bus.vga_x, bus.vga_y, bus.vga_colour, cur.x, cur.y, cur.c);
          end
        end
        if (bus.vga_plot === 1'b1) plot_log.push_back({bus.vga_x, bus.vga_y, bus.vga_colour});
        if (bus.busy === 1'b1) busy_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(string name, int got, int expv);
    n_checks++;
    if (got != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic check_pix(string name, int idx, int x, int y, int c);
    pix_t p;
    p = (idx < plot_log.size()) ? plot_log[idx] : '1;
    check(name, int'(p), int'({8'(x), 7'(y), 3'(c)}));
  endtask

  task automatic set_slot(int i, int x, int y, int c, bit v);
    bus.obj_x[i*X_W +: X_W]           = X_W'(x);
    bus.obj_y[i*Y_W +: Y_W]           = Y_W'(y);
    bus.obj_colour[i*COLOUR_W +: COLOUR_W] = COLOUR_W'(c);
    bus.obj_valid[i]                  = v;
  endtask

  task automatic wait_finish();
    bit ok;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      if (bus.finish_drawing === 1'b1) begin ok = 1; break; end
      tick();
    end
    if (!ok) check("finish_timeout", 0, 1);
  endtask

  task automatic clear_logs();
    plot_log.delete();
    busy_cnt = 0;
  endtask

  task automatic frame();
    bus.draw = 1'b1;
    tick();
    wait_finish();
    bus.draw = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic rand_coord(output int x, output int y);
    x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 159));
    y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 119));
  endtask

  initial begin
    int rx, ry;
    bus.draw = 1'b1;
    set_slot(0, 10, 20, 4, 1);
    set_slot(1, 0, 0, 0, 0);

    // Reset held with draw high, then first frame.
    tick(); tick(); tick();
    check("reset_busy", int'(bus.busy), 0);
    check("reset_plot", int'(bus.vga_plot), 0);
    clear_logs();
    reset = 1'b1;
    tick();
    check("load_after_reset", int'(bus.busy), 1);
    wait_finish();
    bus.draw = 1'b0;
    tick(); tick(); tick();
    check("f1_len", busy_cnt, 9);
    check("f1_plots", plot_log.size(), 4);
    check_pix("f1_p0", 0, 10, 20, 4);
    check_pix("f1_p1", 1, 11, 20, 4);
    check_pix("f1_p2", 2, 10, 21, 4);
    check_pix("f1_p3", 3, 11, 21, 4);

    // Move slot0: erase old square, then paint new one.
    set_slot(0, 10, 22, 4, 1);
    clear_logs();
    frame();
    check("f2_plots", plot_log.size(), 8);
    check_pix("f2_erase0", 0, 10, 20, 0);
    check_pix("f2_erase3", 3, 11, 21, 0);
    check_pix("f2_paint0", 4, 10, 22, 4);
    check_pix("f2_paint3", 7, 11, 23, 4);

    // Bottom-right corner: only one pixel on screen.
    set_slot(0, 159, 119, 4, 1);
    clear_logs();
    frame();
    check("corner_plots", plot_log.size(), 5);
    check_pix("corner_px", 4, 159, 119, 4);
    check("corner_len", busy_cnt, 12);

    // draw held high after completion: no restart.
    bus.draw = 1'b1;
    tick();
    wait_finish();
    tick();
    clear_logs();
    repeat (10) tick();
    check("hold_plots", plot_log.size(), 0);
    check("hold_busy", busy_cnt, 0);
    bus.draw = 1'b0;
    tick();
    bus.draw = 1'b1;
    tick();
    check("restart_load", int'(bus.busy), 1);
    wait_finish();
    bus.draw = 1'b0;
    tick(); tick(); tick();

    // Reset on the second paint pixel, then a frame with nothing to erase.
    set_slot(0, 50, 50, 5, 1);
    bus.draw = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (bus.vga_plot === 1'b1 && bus.vga_colour === 3'd5) break;
      tick();
    end
    tick();
    check("paint_px2_x", int'(bus.vga_x), 51);
    reset = 1'b0;
    tick();
    check("midreset_busy", int'(bus.busy), 0);
    check("midreset_plot", int'(bus.vga_plot), 0);
    bus.draw = 1'b0;
    reset = 1'b1;
    tick(); tick();
    set_slot(0, 60, 60, 3, 1);
    clear_logs();
    frame();
    check("post_reset_plots", plot_log.size(), 4);
    check_pix("post_reset_p0", 0, 60, 60, 3);

    // Randomised frames, with inputs scrambled after LOAD and draw sometimes dropped early.
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        rand_coord(rx, ry);
        set_slot(i, rx, ry, int'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
      end
      bus.draw = 1'b1;
      tick();
      tick();
      for (int i = 0; i < NUM_OBJ; i++) begin
        rand_coord(rx, ry);
        set_slot(i, rx, ry, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 2) == 0) bus.draw = 1'b0;
      wait_finish();
      bus.draw = 1'b0;
      repeat ($urandom_range(2, 4)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
